// File: rtl/instrom_arbiter_pkg.sv
// Shared instruction-ROM map constants and arbiter types.
// Imported by instrom_arbiter and by IFU/LSU exception logic.
package instrom_arbiter_pkg;

   localparam logic [31:0] PC_BASE_ADDR      = 32'h8000_0000;
   localparam int unsigned ROM_DEPTH_DEFAULT = 32;

   // Access-fault code reported for ROM range/alignment errors.
   localparam logic [3:0] INSTROM_ERR_CODE = 4'd1;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_LS   = 2'd2
   } gnt_e;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/instrom_rsp_slot.sv
// One-entry registered response slot for one arbiter port.
// Holds data/err until drained; a same-cycle load overwrites.
module instrom_rsp_slot (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        drain,
   input  logic [31:0] load_data,
   input  logic        load_err,
   output logic        valid,
   output logic [31:0] data,
   output logic        err,
   output logic        avail
);

   assign avail = !valid || drain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= 32'h0;
         err   <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         err   <= load_err;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instrom_arbiter.sv
// IF/LS arbiter for the single-ported instruction ROM.
// Define INSTROM_ARB_ALIGN_CHECK_EN to flag unaligned addresses.
module instrom_arbiter
   import instrom_arbiter_pkg::*;
#(
   parameter int unsigned ROM_DEPTH     = ROM_DEPTH_DEFAULT,
   parameter logic [31:0] BASE_ADDR     = PC_BASE_ADDR,
   parameter int unsigned MAX_IF_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [31:0] if_req_addr,
   output logic        if_rsp_valid,
   input  logic        if_rsp_ready,
   output logic [31:0] if_rsp_data,
   output logic        if_rsp_err,

   input  logic        ls_req_valid,
   output logic        ls_req_ready,
   input  logic [31:0] ls_req_addr,
   output logic        ls_rsp_valid,
   input  logic        ls_rsp_ready,
   output logic [31:0] ls_rsp_data,
   output logic        ls_rsp_err,

   output logic        arb_instrom_ren,
   output logic [31:0] arb_instrom_addr,
   input  logic [31:0] instrom_arb_data
);

   localparam int unsigned SW = $clog2(MAX_IF_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_IF_STREAK);
   localparam logic [32:0] ROM_LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] ROM_HI = ROM_LO + 33'(ROM_DEPTH) * 33'd4;

   generate
      if (MAX_IF_STREAK < 1) begin : g_bad_streak
         $error("MAX_IF_STREAK must be at least 1");
      end
      if ((ROM_DEPTH == 0) || ((ROM_DEPTH & (ROM_DEPTH - 1)) != 0))
      begin : g_bad_depth
         $error("ROM_DEPTH must be a power of 2");
      end
   endgenerate

   logic          if_drain;
   logic          ls_drain;
   logic          if_avail;
   logic          ls_avail;
   logic          if_elig;
   logic          ls_elig;
   logic          if_win;
   logic          ls_win;
   gnt_e          gnt;
   logic          gnt_any;
   logic [31:0]   gnt_addr;
   logic [32:0]   gnt_addr_x;
   logic          out_of_range;
   logic          addr_bad;
   logic [31:0]   rsp_data;
   logic [SW-1:0] streak;

   assign if_drain = if_rsp_valid && if_rsp_ready;
   assign ls_drain = ls_rsp_valid && ls_rsp_ready;

   assign if_elig = if_req_valid && if_avail;
   assign ls_elig = ls_req_valid && ls_avail;

   // LS overrides IF only once IF has used up its streak budget.
   assign if_win = if_elig && !(ls_elig && (streak == STREAK_MAX));
   assign ls_win = ls_elig && !if_win;

   always_comb begin
      gnt      = GNT_NONE;
      gnt_addr = 32'h0;
      unique case (1'b1)
         if_win: begin
            gnt      = GNT_IF;
            gnt_addr = if_req_addr;
         end
         ls_win: begin
            gnt      = GNT_LS;
            gnt_addr = ls_req_addr;
         end
         default: ;
      endcase
   end

   assign gnt_any      = gnt != GNT_NONE;
   assign if_req_ready = gnt == GNT_IF;
   assign ls_req_ready = gnt == GNT_LS;

   // 33-bit compare keeps the top of the address space from wrapping.
   assign gnt_addr_x   = {1'b0, gnt_addr};
   assign out_of_range = (gnt_addr_x < ROM_LO) || (gnt_addr_x >= ROM_HI);

`ifdef INSTROM_ARB_ALIGN_CHECK_EN
   assign addr_bad = out_of_range || misaligned(gnt_addr);
`else
   assign addr_bad = out_of_range;
`endif

   assign arb_instrom_ren  = gnt_any && !addr_bad;
   assign arb_instrom_addr = gnt_addr;
   assign rsp_data         = addr_bad ? 32'h0 : instrom_arb_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak <= '0;
      end else if (!ls_req_valid || (gnt == GNT_LS)) begin
         streak <= '0;
      end else if ((gnt == GNT_IF) && (streak != STREAK_MAX)) begin
         streak <= streak + SW'(1);
      end
   end

   instrom_rsp_slot u_if_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (gnt == GNT_IF),
      .drain     (if_drain),
      .load_data (rsp_data),
      .load_err  (addr_bad),
      .valid     (if_rsp_valid),
      .data      (if_rsp_data),
      .err       (if_rsp_err),
      .avail     (if_avail)
   );

   instrom_rsp_slot u_ls_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (gnt == GNT_LS),
      .drain     (ls_drain),
      .load_data (rsp_data),
      .load_err  (addr_bad),
      .valid     (ls_rsp_valid),
      .data      (ls_rsp_data),
      .err       (ls_rsp_err),
      .avail     (ls_avail)
   );

endmodule
